vend_credit_ctrl: RTL and testbench

Vending-machine transaction controller: detects coin and product-select button presses, keeps the customer credit as two-digit BCD, and issues the one-cycle product/error event pulses and BCD credit that the seven-segment display manager consumes. It is the producer end of the display interface (credit, apple, banana, carrot, date, error), with a refund path for rejected coins and cancel. Sits between the debounced front-panel inputs and the display manager / dispenser actuators.

---
 rtl/vend_credit_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl
//   Vending-machine transaction controller. Detects rising edges on the
//   debounced coin/button levels, keeps the customer credit as two-digit BCD,
//   and emits one-cycle vend/error/refund pulses for the display manager and
//   dispenser. After every accepted event the controller is busy for
//   HOLD_CYCLES cycles, and all edges seen in that window are dropped.
//
// Ports
//   clk                         rising-edge clock
//   reset                       synchronous, active-low reset
//   coin_5/coin_10/coin_25      debounced coin-slot levels
//   sel_a/sel_b/sel_c/sel_d     debounced product buttons
//   cancel                      debounced cancel button
//   credit[7:0]                 current credit, BCD (tens in [7:4])
//   apple/banana/carrot/date    one-cycle vend pulses
//   error                       one-cycle rejected-operation pulse
//   refund[7:0]                 BCD refund amount, qualified by refund_valid
//   refund_valid                one-cycle refund pulse
//   busy                        high while in HOLD

module vend_credit_ctrl #(
    parameter logic [7:0]  PRICE_A     = 8'h25,
    parameter logic [7:0]  PRICE_B     = 8'h35,
    parameter logic [7:0]  PRICE_C     = 8'h50,
    parameter logic [7:0]  PRICE_D     = 8'h75,
    parameter int unsigned HOLD_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       coin_25,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       sel_c,
    input  logic       sel_d,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       apple,
    output logic       banana,
    output logic       carrot,
    output logic       date,
    output logic       error,
    output logic [7:0] refund,
    output logic       refund_valid,
    output logic       busy
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // Bit order doubles as priority order: bit 0 wins.
    logic [7:0] in_lvl;
    assign in_lvl = {sel_d, sel_c, sel_b, sel_a, coin_5, coin_10, coin_25, cancel};

    state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] ev_q, ev_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] refund_q, refund_d;
    logic       rv_q, rv_d;
    logic [4:0] pulse_q, pulse_d;   // {error, date, carrot, banana, apple}

    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic [7:0] price;
    logic [3:0] sel_hot;
    logic [7:0] sel_diff;
    logic       accept;

    // Digit-wise BCD add; bit 8 is the carry out of the tens digit.
    function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] u;
        logic [4:0] t;
        logic       c;
        logic       co;
        u  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        c  = 1'b0;
        if (u > 5'd9) begin
            u = u - 5'd10;
            c = 1'b1;
        end
        t  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, c};
        co = 1'b0;
        if (t > 5'd9) begin
            t  = t - 5'd10;
            co = 1'b1;
        end
        return {co, t[3:0], u[3:0]};
    endfunction

    // Digit-wise BCD subtract; caller guarantees a >= b.
    function automatic logic [7:0] bcd_sub(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] u;
        logic [4:0] t;
        logic       bw;
        if (a[3:0] < b[3:0]) begin
            u  = {1'b0, a[3:0]} + 5'd10 - {1'b0, b[3:0]};
            bw = 1'b1;
        end else begin
            u  = {1'b0, a[3:0]} - {1'b0, b[3:0]};
            bw = 1'b0;
        end
        t = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'd0, bw};
        return {t[3:0], u[3:0]};
    endfunction

    // Operand selection for whichever coin/product edge has priority.
    always_comb begin
        coin_val = 8'h05;
        if (ev_q[1]) begin
            coin_val = 8'h25;
        end else if (ev_q[2]) begin
            coin_val = 8'h10;
        end

        sel_hot = 4'b1000;
        price   = PRICE_D;
        if (ev_q[4]) begin
            sel_hot = 4'b0001;
            price   = PRICE_A;
        end else if (ev_q[5]) begin
            sel_hot = 4'b0010;
            price   = PRICE_B;
        end else if (ev_q[6]) begin
            sel_hot = 4'b0100;
            price   = PRICE_C;
        end
    end

    assign coin_sum = bcd_add(credit_q, coin_val);
    assign sel_diff = bcd_sub(credit_q, price);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        refund_d = refund_q;
        rv_d     = 1'b0;
        pulse_d  = '0;
        accept   = 1'b0;
        // Edge registers run every cycle so edges during HOLD are consumed.
        prev_d   = in_lvl;
        ev_d     = in_lvl & ~prev_q;

        case (state_q)
            IDLE: begin
                if (ev_q[0]) begin
                    if (credit_q != 8'h00) begin
                        refund_d = credit_q;
                        rv_d     = 1'b1;
                        credit_d = 8'h00;
                        accept   = 1'b1;
                    end
                end else if (|ev_q[3:1]) begin
                    accept = 1'b1;
                    if (!coin_sum[8]) begin
                        credit_d = coin_sum[7:0];
                    end else begin
                        pulse_d[4] = 1'b1;
                        refund_d   = coin_val;
                        rv_d       = 1'b1;
                    end
                end else if (|ev_q[7:4]) begin
                    accept = 1'b1;
                    // Valid BCD orders the same as plain binary.
                    if (credit_q >= price) begin
                        credit_d     = sel_diff;
                        pulse_d[3:0] = sel_hot;
                    end else begin
                        pulse_d[4] = 1'b1;
                    end
                end
                if (accept) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= '1;
            ev_q     <= '0;
            credit_q <= '0;
            refund_q <= '0;
            rv_q     <= 1'b0;
            pulse_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            ev_q     <= ev_d;
            credit_q <= credit_d;
            refund_q <= refund_d;
            rv_q     <= rv_d;
            pulse_q  <= pulse_d;
        end
    end

    assign credit       = credit_q;
    assign refund       = refund_q;
    assign refund_valid = rv_q;
    assign apple        = pulse_q[0];
    assign banana       = pulse_q[1];
    assign carrot       = pulse_q[2];
    assign date         = pulse_q[3];
    assign error        = pulse_q[4];
    assign busy         = (state_q == HOLD);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
module tb_vend_credit_ctrl;

    localparam int unsigned HOLD = 6;

    localparam logic [7:0] M_CANCEL = 8'h01;
    localparam logic [7:0] M_C25    = 8'h02;
    localparam logic [7:0] M_C10    = 8'h04;
    localparam logic [7:0] M_C5     = 8'h08;
    localparam logic [7:0] M_SA     = 8'h10;
    localparam logic [7:0] M_SB     = 8'h20;
    localparam logic [7:0] M_SD     = 8'h80;

    logic       clk;
    logic       reset;
    logic       coin_5, coin_10, coin_25;
    logic       sel_a, sel_b, sel_c, sel_d;
    logic       cancel;
    logic [7:0] credit;
    logic       apple, banana, carrot, date, error;
    logic [7:0] refund;
    logic       refund_valid;
    logic       busy;

    vend_credit_ctrl #(
        .PRICE_A(8'h25),
        .PRICE_B(8'h35),
        .PRICE_C(8'h50),
        .PRICE_D(8'h75),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coin_5(coin_5),
        .coin_10(coin_10),
        .coin_25(coin_25),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .sel_c(sel_c),
        .sel_d(sel_d),
        .cancel(cancel),
        .credit(credit),
        .apple(apple),
        .banana(banana),
        .carrot(carrot),
        .date(date),
        .error(error),
        .refund(refund),
        .refund_valid(refund_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] credit;
        logic [4:0] pulses;   // {error, date, carrot, banana, apple}
        logic       rv;
        logic [7:0] refund;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mcredit  = 0;
    int   mrefund  = 0;
    int   prices[4] = '{25, 35, 50, 75};

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic drive(input logic [7:0] m);
        {sel_d, sel_c, sel_b, sel_a, coin_5, coin_10, coin_25, cancel} = m;
    endtask

    // Decimal reference model of one accepted edge set.
    task automatic model(input logic [7:0] m, output exp_t e);
        int v;
        int k;
        e.pulses = '0;
        e.rv     = 1'b0;
        e.busy   = 1'b1;
        if (m[0]) begin
            if (mcredit != 0) begin
                mrefund = mcredit;
                e.rv    = 1'b1;
                mcredit = 0;
            end else begin
                e.busy = 1'b0;
            end
        end else if (m[3:1] != 3'b000) begin
            v = m[1] ? 25 : (m[2] ? 10 : 5);
            if (mcredit + v <= 99) begin
                mcredit = mcredit + v;
            end else begin
                e.pulses[4] = 1'b1;
                mrefund     = v;
                e.rv        = 1'b1;
            end
        end else if (m[7:4] != 4'b0000) begin
            k = m[4] ? 0 : (m[5] ? 1 : (m[6] ? 2 : 3));
            if (mcredit >= prices[k]) begin
                mcredit     = mcredit - prices[k];
                e.pulses[k] = 1'b1;
            end else begin
                e.pulses[4] = 1'b1;
            end
        end else begin
            e.busy = 1'b0;
        end
        e.credit = to_bcd(mcredit);
        e.refund = to_bcd(mrefund);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mcredit = 0;
        mrefund = 0;
    endtask

    // Compare the popped expectation with the DUT in the result cycle.
    task automatic compare_result(input string name);
        exp_t e;
        logic [4:0] obs_p;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        obs_p = {error, date, carrot, banana, apple};
        n_checks++;
        if (credit !== e.credit) $display("FAIL %s credit: got %h want %h", name, credit, e.credit);
        else n_pass++;
        n_checks++;
        if (obs_p !== e.pulses) $display("FAIL %s pulses: got %b want %b", name, obs_p, e.pulses);
        else n_pass++;
        n_checks++;
        if (refund_valid !== e.rv) $display("FAIL %s refund_valid: got %b want %b", name, refund_valid, e.rv);
        else n_pass++;
        n_checks++;
        if (refund !== e.refund) $display("FAIL %s refund: got %h want %h", name, refund, e.refund);
        else n_pass++;
        n_checks++;
        if (busy !== e.busy) $display("FAIL %s busy: got %b want %b", name, busy, e.busy);
        else n_pass++;
    endtask

    // Called at a negedge: raise inputs, check the result two edges later,
    // then pulse hold_m once inside HOLD and measure the busy length.
    task automatic press(input logic [7:0] m, input logic [7:0] hold_m, input string name);
        exp_t e;
        int cnt;
        int stray;
        logic want_busy;
        model(m, e);
        want_busy = e.busy;
        sb.push_back(e);
        drive(m);
        @(negedge clk);
        @(negedge clk);
        compare_result(name);
        cnt   = 0;
        stray = 0;
        if (want_busy) begin
            while (busy === 1'b1 && cnt < 50) begin
                if (cnt > 0 && ({error, date, carrot, banana, apple, refund_valid} != 6'b0)) stray++;
                drive(cnt == 1 ? hold_m : 8'h00);
                cnt++;
                @(negedge clk);
            end
            drive(8'h00);
            n_checks++;
            if (cnt != HOLD) $display("FAIL %s busy_len: got %0d want %0d", name, cnt, HOLD);
            else n_pass++;
            n_checks++;
            if (stray != 0) $display("FAIL %s hold_quiet: got %0d pulses want 0", name, stray);
            else n_pass++;
        end else begin
            drive(8'h00);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL %s idle_after: got busy %b want 0", name, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(M_C25);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({credit, refund, refund_valid, busy, error, date, carrot, banana, apple} !== 26'd0)
            $display("FAIL reset_state: got credit %h refund %h rv %b busy %b", credit, refund, refund_valid, busy);
        else n_pass++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (credit !== 8'h00 || busy !== 1'b0)
            $display("FAIL held_through_reset: got credit %h busy %b want 00/0", credit, busy);
        else n_pass++;
        drive(8'h00);
        @(negedge clk);
        mcredit = 0;
        mrefund = 0;
    endtask

    task automatic test_coins();
        press(M_C25, 8'h00, "coin25_a");
        press(M_C25, 8'h00, "coin25_b");
        press(M_C25, 8'h00, "coin25_c");
    endtask

    task automatic test_select();
        press(M_SD, 8'h00, "sel_d_75");
        press(M_SA, 8'h00, "sel_a_empty");
    endtask

    task automatic test_overflow();
        press(M_C25, 8'h00, "ovf_fill1");
        press(M_C25, 8'h00, "ovf_fill2");
        press(M_C25, 8'h00, "ovf_fill3");
        press(M_C5,  8'h00, "ovf_fill4");
        press(M_C25, 8'h00, "ovf_80p25");
        press(M_C10, 8'h00, "ovf_80p10");
        press(M_C10, 8'h00, "ovf_90p10");
    endtask

    task automatic test_bcd();
        do_reset();
        press(M_C5,  8'h00, "bcd_05");
        press(M_C5,  8'h00, "bcd_10");
        press(M_C25, 8'h00, "bcd_35");
        press(M_SB,  8'h00, "bcd_sel_b");
        press(M_C25, 8'h00, "bcd_25");
        press(M_C10, 8'h00, "bcd_35b");
        press(M_C5,  8'h00, "bcd_40");
        press(M_SA,  8'h00, "bcd_40m25");
    endtask

    task automatic test_same_cycle();
        do_reset();
        press(M_C10, 8'h00, "same_10");
        press(M_C10, 8'h00, "same_20");
        press(M_C10 | M_SA, M_SA, "same_coin_sel");
        press(M_CANCEL | M_C25 | M_SD, 8'h00, "same_cancel_wins");
    endtask

    task automatic test_cancel();
        do_reset();
        press(M_C25, 8'h00, "cancel_25");
        press(M_C10, 8'h00, "cancel_35");
        press(M_C10, 8'h00, "cancel_45");
        press(M_CANCEL, 8'h00, "cancel_45_refund");
        press(M_CANCEL, 8'h00, "cancel_noop");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int guard;
        do_reset();
        model(M_C25, e);
        sb.push_back(e);
        drive(M_C25);
        @(negedge clk);
        @(negedge clk);
        compare_result("b2b_first");
        drive(8'h00);
        repeat (HOLD - 2) @(negedge clk);
        // Rises one cycle too early: must be lost.
        drive(M_C10);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_last_busy: got %b want 1", busy);
        else n_pass++;
        // Earliest edge that may be accepted.
        drive(M_C10 | M_C5);
        model(M_C5, e);
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_gap: got busy %b want 0", busy);
        else n_pass++;
        @(negedge clk);
        compare_result("b2b_second");
        drive(8'h00);
        guard = 0;
        while (busy === 1'b1 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        n_checks++;
        if (guard != HOLD) $display("FAIL b2b_busy_len: got %0d want %0d", guard, HOLD);
        else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        exp_t e;
        do_reset();
        press(M_C25, 8'h00, "rih_25");
        model(M_C10, e);
        sb.push_back(e);
        drive(M_C10);
        @(negedge clk);
        @(negedge clk);
        compare_result("rih_35");
        drive(8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mcredit = 0;
        mrefund = 0;
        n_checks++;
        if (credit !== 8'h00 || busy !== 1'b0 || refund_valid !== 1'b0)
            $display("FAIL reset_in_hold: got credit %h busy %b rv %b want 00/0/0", credit, busy, refund_valid);
        else n_pass++;
        @(negedge clk);
        press(M_C5, 8'h00, "rih_after");
    endtask

    initial begin
        reset = 1'b0;
        drive(8'h00);
        @(negedge clk);
        test_reset();
        test_coins();
        test_select();
        test_overflow();
        test_bcd();
        test_same_cycle();
        test_cancel();
        test_back_to_back();
        test_reset_in_hold();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
